// File: rtl/exec_alu_unit_if.sv
// rtl/exec_alu_unit_if.sv - operand/control inputs and registered results of the execute-stage ALU
interface exec_alu_unit_if;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] imm;
  logic        alu_src;
  logic [31:0] pc_inc;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] branch_addr;
  logic [2:0]  alu_ctrl;

  modport master (
    output alu_op, funct, operand_a, operand_b, imm, alu_src, pc_inc,
    input  alu_result, zero, branch_addr, alu_ctrl
  );

  modport slave (
    input  alu_op, funct, operand_a, operand_b, imm, alu_src, pc_inc,
    output alu_result, zero, branch_addr, alu_ctrl
  );
endinterface

// File: rtl/exec_alu_unit.sv
// rtl/exec_alu_unit.sv - execute-stage ALU with control decode and branch adder, one-cycle registered outputs
module exec_alu_unit (
  input logic             clk,
  input logic             reset,
  exec_alu_unit_if.slave  bus
);
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_NOR = 3'b100;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  logic [2:0]  ctrl_d;
  logic [31:0] op_b;
  logic [31:0] result_d;
  logic [31:0] branch_d;

  // Every unlisted or unknown encoding falls to the default arm, so alu_ctrl is always ADD then.
  always_comb begin
    ctrl_d = CTRL_ADD;
    case (bus.alu_op)
      3'b000: ctrl_d = CTRL_ADD;
      3'b001: ctrl_d = CTRL_SUB;
      3'b010: begin
        case (bus.funct)
          6'b100000: ctrl_d = CTRL_ADD;
          6'b100010: ctrl_d = CTRL_SUB;
          6'b100100: ctrl_d = CTRL_AND;
          6'b100101: ctrl_d = CTRL_OR;
          6'b100111: ctrl_d = CTRL_NOR;
          6'b101010: ctrl_d = CTRL_SLT;
          default:   ctrl_d = CTRL_ADD;
        endcase
      end
      3'b011:  ctrl_d = CTRL_AND;
      3'b100:  ctrl_d = CTRL_OR;
      3'b101:  ctrl_d = CTRL_SLT;
      default: ctrl_d = CTRL_ADD;
    endcase
  end

  always_comb begin
    op_b     = bus.alu_src ? bus.imm : bus.operand_b;
    result_d = 32'd0;
    case (ctrl_d)
      CTRL_AND: result_d = bus.operand_a & op_b;
      CTRL_OR:  result_d = bus.operand_a | op_b;
      CTRL_ADD: result_d = bus.operand_a + op_b;
      CTRL_NOR: result_d = ~(bus.operand_a | op_b);
      CTRL_SUB: result_d = bus.operand_a - op_b;
      CTRL_SLT: result_d = {31'd0, $signed(bus.operand_a) < $signed(op_b)};
      default:  result_d = 32'd0;
    endcase
    branch_d = bus.pc_inc + {bus.imm[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_result  <= 32'd0;
      bus.zero        <= 1'b0;
      bus.branch_addr <= 32'd0;
      bus.alu_ctrl    <= CTRL_ADD;
    end else begin
      bus.alu_result  <= result_d;
      bus.zero        <= (result_d == 32'd0);
      bus.branch_addr <= branch_d;
      bus.alu_ctrl    <= ctrl_d;
    end
  end
endmodule

// File: tb/tb_exec_alu_unit.sv
// tb/tb_exec_alu_unit.sv - randomized self-checking bench for exec_alu_unit against a behavioural model
module tb_exec_alu_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exec_alu_unit_if bus ();

  exec_alu_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference operation naming: 0=ADD 1=SUB 2=AND 3=OR 4=NOR 5=SLT
  function automatic int model_kind(input logic [2:0] op, input logic [5:0] fn);
    if (op == 3'd1) return 1;
    if (op == 3'd3) return 2;
    if (op == 3'd4) return 3;
    if (op == 3'd5) return 5;
    if (op == 3'd2) begin
      if (fn == 6'd34) return 1;
      if (fn == 6'd36) return 2;
      if (fn == 6'd37) return 3;
      if (fn == 6'd39) return 4;
      if (fn == 6'd42) return 5;
    end
    return 0;
  endfunction

  function automatic logic [2:0] model_code(input int kind);
    logic [2:0] codes [6] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd4, 3'd7};
    return codes[kind];
  endfunction

  function automatic logic [31:0] model_result(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (kind)
      1:       return 32'(longint'(a) - longint'(b));
      2:       return a & b;
      3:       return a | b;
      4:       return ~(a | b);
      5:       return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'(longint'(a) + longint'(b));
    endcase
  endfunction

  task automatic run_op(input string tag, input logic rst, input logic [2:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic src, input logic [31:0] pc);
    logic [31:0] e_res, e_br;
    logic [2:0]  e_ctrl;
    logic        e_zero;
    int          kind;
    reset         = rst;
    bus.alu_op    = op;
    bus.funct     = fn;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.imm       = im;
    bus.alu_src   = src;
    bus.pc_inc    = pc;
    kind   = model_kind(op, fn);
    e_res  = model_result(kind, a, src ? im : b);
    e_zero = (e_res == 32'd0);
    e_br   = 32'(longint'(pc) + 4 * longint'($signed(im)));
    e_ctrl = model_code(kind);
    if (rst) begin
      e_res  = 32'd0;
      e_zero = 1'b0;
      e_br   = 32'd0;
      e_ctrl = 3'd2;
    end
    @(posedge clk);
    #1;
    check({tag, ".result"}, bus.alu_result, e_res);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, e_zero});
    check({tag, ".branch"}, bus.branch_addr, e_br);
    check({tag, ".ctrl"}, {29'd0, bus.alu_ctrl}, {29'd0, e_ctrl});
  endtask

  initial begin
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [5:0]  fn_list [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    logic [31:0] a, b, im;
    bus.alu_op = 3'd0; bus.funct = 6'd0; bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    bus.imm = 32'd0; bus.alu_src = 1'b0; bus.pc_inc = 32'd0;

    run_op("reset_state", 1'b1, 3'b001, 6'd0, 32'd9, 32'd3, 32'd5, 1'b0, 32'd100);
    check("r_add.result_lit", 32'd0, 32'd0 + bus.alu_result);
    run_op("r_add", 1'b0, 3'b010, 6'b100000, 32'd7, 32'd5, 32'd0, 1'b0, 32'd0);
    check("r_add.is12", bus.alu_result, 32'd12);
    run_op("beq_sub", 1'b0, 3'b001, 6'd0, 32'h1234, 32'h1234, 32'd3, 1'b0, 32'd40);
    check("beq_sub.br52", bus.branch_addr, 32'd52);
    run_op("neg_off", 1'b0, 3'b000, 6'd0, 32'd1, 32'd2, 32'hFFFFFFFE, 1'b0, 32'd8);
    check("neg_off.br0", bus.branch_addr, 32'd0);
    run_op("add_ovf", 1'b0, 3'b000, 6'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1, 32'd0);
    check("add_ovf.zero1", {31'd0, bus.zero}, 32'd1);
    run_op("slt_neg", 1'b0, 3'b010, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0);
    check("slt_neg.is1", bus.alu_result, 32'd1);
    run_op("nor_zero", 1'b0, 3'b010, 6'b100111, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    check("nor_zero.ones", bus.alu_result, 32'hFFFFFFFF);
    run_op("bad_funct", 1'b0, 3'b010, 6'b111111, 32'd3, 32'd4, 32'd0, 1'b0, 32'd0);
    run_op("op110", 1'b0, 3'b110, 6'b100010, 32'd10, 32'd4, 32'd0, 1'b0, 32'd0);
    run_op("op111", 1'b0, 3'b111, 6'b100100, 32'd10, 32'd4, 32'd0, 1'b0, 32'd0);
    run_op("mid_reset", 1'b1, 3'b010, 6'b100000, 32'd7, 32'd5, 32'd1, 1'b0, 32'd4);
    run_op("post_reset", 1'b0, 3'b010, 6'b100000, 32'd7, 32'd5, 32'd0, 1'b0, 32'd0);
    check("post_reset.is12", bus.alu_result, 32'd12);

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 5)];
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
      im = 32'($signed(16'($urandom)));
      run_op("rand", ($urandom_range(0, 19) == 0), op, fn, a, b, im, 1'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
